// File: rtl/fifo_pkg.sv
// Pointer helpers shared by the read- and write-side FIFO controllers.
// Functions work on a wide zero-extended value; callers truncate back to ADDRSIZE+1 bits.
package fifo_pkg;

  localparam int PTR_MAX = 32;

  typedef logic [PTR_MAX-1:0] ptr_t;

  function automatic int unsigned fifo_depth(input int unsigned addrsize);
    return 32'd1 << addrsize;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Zero upper bits leave the prefix-XOR unchanged, so any pointer width decodes correctly.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_MAX-1] = g[PTR_MAX-1];
    for (int i = PTR_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync2.sv
// Two-flop synchroniser for a Gray-coded pointer crossing into the clk domain.
module gray_sync2 #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: synchroniser flops get the async reset so both domains restart from pointer 0 together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer/flag controller of the dual-clock FIFO (rclk domain).
// Define FIFO_RD_WPTR_SYNC_EN to synchronise wptr_gray internally (adds 2 rclk of write visibility latency).
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE  = 4,
  parameter int AE_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rst,
  input  logic                rd_en,
  input  logic [ADDRSIZE:0]   wptr_gray,
  output logic [ADDRSIZE-1:0] rd_addr,
  output logic [ADDRSIZE:0]   rptr_gray,
  output logic                empty,
  output logic                almost_empty,
  output logic [ADDRSIZE:0]   rd_level,
  output logic                underflow
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [ADDRSIZE:0] AE_LIMIT = PW'(AE_THRESH);

  logic [ADDRSIZE:0] wq;
  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] rbin_next;
  logic [ADDRSIZE:0] rgray_next;
  logic [ADDRSIZE:0] level_next;
  logic              rd_fire;

`ifdef FIFO_RD_WPTR_SYNC_EN
  gray_sync2 #(.WIDTH(PW)) u_wptr_sync (
    .clk (rclk),
    .rst (rst),
    .d   (wptr_gray),
    .q   (wq)
  );
`else
  assign wq = wptr_gray;
`endif

  // Registered empty gates the read, so nothing is consumed while empty is shown.
  assign rd_fire    = rd_en & ~empty;
  assign rbin_next  = rbin + {{ADDRSIZE{1'b0}}, rd_fire};
  assign rgray_next = PW'(bin2gray(ptr_t'(rbin_next)));
  assign wbin       = PW'(gray2bin(ptr_t'(wq)));
  assign level_next = wbin - rbin_next;
  assign rd_addr    = rbin[ADDRSIZE-1:0];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      rbin         <= '0;
      rptr_gray    <= '0;
      rd_level     <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      underflow    <= 1'b0;
    end else begin
      rbin         <= rbin_next;
      rptr_gray    <= rgray_next;
      rd_level     <= level_next;
      empty        <= (rgray_next == wq);
      almost_empty <= (level_next <= AE_LIMIT);
      underflow    <= rd_en & empty;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: count-based reference model plus directed literal checks.
module tb_fifo_rd_ctrl;

  localparam int ADDRSIZE = 4;
  localparam int AE       = 2;
  localparam int DEPTH    = 16;
`ifdef FIFO_RD_WPTR_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic                rclk = 1'b0;
  logic                rst  = 1'b1;
  logic                rd_en = 1'b0;
  logic [ADDRSIZE:0]   wptr_gray = '0;
  logic [ADDRSIZE-1:0] rd_addr;
  logic [ADDRSIZE:0]   rptr_gray;
  logic                empty;
  logic                almost_empty;
  logic [ADDRSIZE:0]   rd_level;
  logic                underflow;

  fifo_rd_ctrl #(.ADDRSIZE(ADDRSIZE), .AE_THRESH(AE)) dut (
    .rclk         (rclk),
    .rst          (rst),
    .rd_en        (rd_en),
    .wptr_gray    (wptr_gray),
    .rd_addr      (rd_addr),
    .rptr_gray    (rptr_gray),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rd_level     (rd_level),
    .underflow    (underflow)
  );

  always #5 rclk = ~rclk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gray_of(input int n);
    int x;
    x = n % (2 * DEPTH);
    return x ^ (x >> 1);
  endfunction

  // Model state: total words written/read as plain counts, and what the reader has seen.
  int wcnt = 0;
  int m_rcnt = 0;
  int m_level = 0;
  bit m_under = 1'b0;
  int hist[$];
  bit rst_evt = 1'b0;

  task automatic set_w(input int n);
    wcnt = n;
    wptr_gray = (ADDRSIZE+1)'(gray_of(n));
  endtask

  always @(posedge rclk or posedge rst) begin
    int seen;
    if (rst) begin
      m_rcnt  = 0;
      m_level = 0;
      m_under = 1'b0;
      hist    = {};
      for (int i = 0; i < SYNC_LAT; i++) hist.push_back(0);
      rst_evt = 1'b1;
    end else begin
      if (SYNC_LAT == 0) begin
        seen = wcnt;
      end else begin
        seen = hist.pop_front();
        hist.push_back(wcnt);
      end
      m_under = rd_en && (m_level == 0);
      if (rd_en && m_level != 0) m_rcnt++;
      m_level = seen - m_rcnt;
    end
  end

  logic [ADDRSIZE:0]   prev_gray = '0;
  logic [ADDRSIZE-1:0] prev_addr = '0;
  bit addr_wrap = 1'b0;
  bit gray_wrap = 1'b0;

  always @(negedge rclk) begin
    check("addr", rd_addr, m_rcnt % DEPTH);
    check("rptr_gray", rptr_gray, gray_of(m_rcnt));
    check("level", rd_level, m_level);
    check("empty", empty, m_level == 0);
    check("almost_empty", almost_empty, m_level <= AE);
    check("underflow", underflow, m_under);
    if (!rst && !rst_evt) begin
      if (prev_gray != rptr_gray) check("gray_1bit", $countones(prev_gray ^ rptr_gray), 1);
      if (prev_addr == 4'd15 && rd_addr == 4'd0) addr_wrap = 1'b1;
      if (prev_gray == 5'b10000 && rptr_gray == 5'b00000) gray_wrap = 1'b1;
    end
    prev_gray = rptr_gray;
    prev_addr = rd_addr;
    rst_evt   = 1'b0;
  end

  task automatic measure_latency(input int n_words);
    int edges;
    edges = 0;
    @(negedge rclk);
    set_w(n_words);
    do begin
      @(posedge rclk);
      edges++;
      #1;
    end while (rd_level == 0 && edges < 10);
    check("wr_latency", edges, SYNC_LAT + 1);
    check("level_after_wr", rd_level, n_words);
  endtask

  task automatic stream(input int target_reads, input int max_cycles);
    int n;
    n = 0;
    while (m_rcnt < target_reads && n < max_cycles) begin
      @(negedge rclk);
      rd_en = ($urandom_range(0, 3) != 0);
      if (wcnt - m_rcnt < DEPTH && $urandom_range(0, 3) != 0) set_w(wcnt + 1);
      n++;
    end
    check("stream_budget", m_rcnt >= target_reads, 1);
    @(negedge rclk);
    rd_en = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge rclk);
    check("rst_empty", empty, 1);
    check("rst_ae", almost_empty, 1);
    check("rst_level", rd_level, 0);
    rst = 1'b0;
    repeat (4) @(negedge rclk);
    check("idle_empty", empty, 1);
    check("idle_gray", rptr_gray, 0);

    measure_latency(5);
    check("prime_empty", empty, 0);
    check("prime_ae", almost_empty, 0);

    for (int i = 0; i < 5; i++) begin
      @(negedge rclk);
      check("rd_addr_seq", rd_addr, i);
      rd_en = 1'b1;
      @(posedge rclk);
      #1;
      check("rd_level_seq", rd_level, 4 - i);
      check("ae_seq", almost_empty, (4 - i) <= AE);
    end
    check("drained_empty", empty, 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge rclk);
      #1;
      check("underflow_pulse", underflow, 1);
      check("underflow_addr", rd_addr, 5);
      check("underflow_gray", rptr_gray, 7);
    end
    @(negedge rclk);
    rd_en = 1'b0;
    @(posedge rclk);
    #1;
    check("underflow_clear", underflow, 0);

    stream(45, 2000);
    stream(100, 3000);

    @(negedge rclk);
    set_w(m_rcnt + DEPTH);
    repeat (SYNC_LAT + 2) @(negedge rclk);
    check("full_level", rd_level, DEPTH);
    check("full_empty", empty, 0);
    set_w(wcnt + 1);
    repeat (SYNC_LAT) @(negedge rclk);
    rd_en = 1'b1;
    @(posedge rclk);
    #1;
    check("full_rd_wr", rd_level, DEPTH);
    repeat (9) @(posedge rclk);
    @(negedge rclk);
    rd_en = 1'b0;
    @(negedge rclk);
    check("pre_rst_level", rd_level, 7);

    #1;
    rst = 1'b1;
    set_w(0);
    #1;
    check("async_level", rd_level, 0);
    check("async_empty", empty, 1);
    check("async_ae", almost_empty, 1);
    check("async_addr", rd_addr, 0);
    check("async_gray", rptr_gray, 0);
    check("async_under", underflow, 0);
    @(negedge rclk);
    @(negedge rclk);
    rst = 1'b0;
    repeat (3) @(negedge rclk);

    measure_latency(3);
    stream(60, 2000);

    check("addr_wrap_seen", addr_wrap, 1);
    check("gray_wrap_seen", gray_wrap, 1);
    repeat (2) @(negedge rclk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side pointer/flag controller for the dual-clock FIFO, and the parametrised successor to the existing read pointer/empty logic. Lives in the rclk domain. Takes the write pointer (Gray) from the write domain and produces:
- RAM read address
- Gray read pointer for the write domain
- registered empty, almost_empty and fill-level outputs
- an underflow pulse

Parameters:
ADDRSIZE, 4, RAM address width; FIFO depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits.
AE_THRESH, 2, almost_empty asserts when level <= AE_THRESH; legal range 0..2**ADDRSIZE-1.

Ports:
rclk  in  1  read clock.
rst  in  1  reset; asynchronous, active-high.
rd_en  in  1  read request from consumer.
wptr_gray  in  ADDRSIZE+1  write pointer, Gray-coded (raw or pre-synchronised, see Optional Feature).
rd_addr  out  ADDRSIZE  RAM read address = low ADDRSIZE bits of binary read pointer.
rptr_gray  out  ADDRSIZE+1  registered Gray read pointer, to write-domain synchroniser.
empty  out  1  registered; no readable words.
almost_empty  out  1  registered; level <= AE_THRESH.
rd_level  out  ADDRSIZE+1  registered words available, 0..2**ADDRSIZE.
underflow  out  1  one-cycle pulse: rd_en while empty.

Behaviour:
- Reset (async assert, sync release into rclk):
  - rbin=0, rptr_gray=0, rd_level=0
  - empty=1, almost_empty=1, underflow=0
  - synchroniser flops = 0
- Read accept: rd_fire = rd_en & ~empty. Uses the registered empty, so a read is never accepted in the cycle empty is 1.
- rbin_next = rbin + rd_fire, modulo 2**(ADDRSIZE+1); natural wrap with no special case. rd_addr is combinationally driven from the rbin register (not rbin_next).
- rptr_gray <= bin2gray(rbin_next). Only one bit changes per increment.
- wq = synchronised wptr_gray; wbin = gray2bin(wq), combinational.
- Empty and level:
  - empty <= (bin2gray(rbin_next) == wq)
  - rd_level <= (wbin - rbin_next) mod 2**(ADDRSIZE+1)
  - almost_empty <= (level_next <= AE_THRESH)
  - empty and rd_level==0 are always consistent.
- Latency:
  - Read consumed at edge N → rd_addr, rptr_gray, flags updated at edge N.
  - Write pointer change → visible in flags after synchroniser latency + 1 rclk.
- Pessimism: the flags are conservative. A write may be unseen for a few cycles, so empty/level may lag high/low, but they never overstate available data.
- Simultaneous read accept and wptr advance in one cycle: level_next uses both (net change may be 0).
- underflow <= rd_en & empty. No pointer movement; deasserts next cycle unless repeated.
- rd_level upper bound: level = 2**ADDRSIZE (full) is legal and distinguished from 0 by the MSB.
- Reset mid-operation: all state returns to reset values immediately. Downstream must reset both domains together.

Optional Feature:
Macro FIFO_RD_WPTR_SYNC_EN.
- Defined: wptr_gray passes through an internal 2-flop synchroniser clocked by rclk and reset by rst before use. Adds 2 rclk latency on write visibility.
- Undefined: wptr_gray is treated as already synchronised into rclk and used directly. Port list is identical either way.

Decomposition:
- Package fifo_pkg:
  - functions bin2gray and gray2bin, parameterised by width via ADDRSIZE+1 argument size
  - localparam-style helpers for depth
  - shared with the write-side controller
- Sub-module gray_sync2: an (ADDRSIZE+1)-wide 2-flop synchroniser, async reset. Instantiated only under FIFO_RD_WPTR_SYNC_EN; reused by the write side for rptr.

Test Plan:
- Reset, then idle with wptr_gray=0: empty=1, almost_empty=1, rd_level=0, rd_addr=0, rptr_gray=0 every cycle.
- Write side drives wptr_gray = bin2gray(5) with ADDRSIZE=4, AE_THRESH=2:
  - after sync latency, rd_level=5, empty=0, almost_empty=0
  - 3 back-to-back reads give rd_addr 0,1,2 and rd_level 4,3,2
  - almost_empty rises with level 2; empty rises after 5 reads
- rd_en held high while empty for 3 cycles: underflow pulses each cycle; rbin, rptr_gray, rd_addr unchanged.
- Wrap: stream 40 words through (write side stays ahead):
  - rd_addr wraps 15→0
  - rptr_gray wraps 31→0 as Gray 5'b10000→5'b00000
  - every rptr_gray transition changes exactly 1 bit
- Full: wptr = rptr + 16 → rd_level=16, empty=0. Simultaneous read and one-word write in the same cycle → rd_level stays 16.
- Assert rst mid-stream with level 7: all outputs go to reset values asynchronously, before the next rclk edge. Repeat with and without FIFO_RD_WPTR_SYNC_EN, checking the 2-cycle latency difference.
